// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default widths for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned N_PORTS_DEF = 8;
  localparam int unsigned ADDR_W_DEF  = 9;
  localparam int unsigned DATA_W_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request picker: round-robin from ptr, or lowest-index-wins
// when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N     = N_PORTS_DEF,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int unsigned pos;
    pos   = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
`else
    // Scan upward from ptr with wrap; the first hit wins.
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr) + k) % N;
      if (!valid && req[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
`endif
    if (valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes per-core req/ack transactions onto a single-port RAM, one every
// three cycles. Define MEM_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_PORTS = N_PORTS_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req,
  input  logic [N_PORTS-1:0]        we,
  input  logic [N_PORTS*ADDR_W-1:0] addr,
  input  logic [N_PORTS*DATA_W-1:0] wdata,
  output logic [N_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_write_en,
  output logic                      ram_read_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data_in,
  input  logic [DATA_W-1:0]         ram_data_out
);

  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  state_t             state, state_nxt;
  logic [N_PORTS-1:0] grant, g_onehot;
  logic [IDX_W-1:0]   win_idx, g_idx, rr_ptr;
  logic               win_valid, g_we;
  logic [DATA_W-1:0]  rdata_q;

  rr_arbiter #(.N(N_PORTS), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (win_valid) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes, ack and the read bypass are gated by rst so a reset landing in
  // ISSUE or DONE suppresses them in that same cycle.
  always_comb begin
    ram_write_en = 1'b0;
    ram_read_en  = 1'b0;
    ack          = '0;
    rdata        = rdata_q;
    if (!rst) begin
      if (state == S_ISSUE) begin
        ram_write_en = g_we;
        ram_read_en  = !g_we;
      end
      if (state == S_DONE) begin
        ack = g_onehot;
        if (!g_we) rdata = ram_data_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      g_idx       <= '0;
      g_onehot    <= '0;
      g_we        <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      rdata_q     <= '0;
      rr_ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && win_valid) begin
        g_idx       <= win_idx;
        g_onehot    <= grant;
        g_we        <= we[win_idx];
        ram_addr    <= addr[win_idx*ADDR_W +: ADDR_W];
        ram_data_in <= wdata[win_idx*DATA_W +: DATA_W];
      end
      if (state == S_DONE) begin
        if (!g_we) rdata_q <= ram_data_out;
`ifdef MEM_ARB_FIXED_PRIO_EN
        rr_ptr <= '0;
`else
        rr_ptr <= (32'(g_idx) == N_PORTS - 1) ? '0 : g_idx + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural RAM and model.
module tb_mem_port_arbiter;

  localparam int N  = 8;
  localparam int AW = 9;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            ram_write_en, ram_read_en;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .ack          (ack),
    .rdata        (rdata),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  function automatic logic [DW-1:0] pre(int i);
    return 16'(i * 7) ^ 16'hA500;
  endfunction

  // RAM with registered read address; preloaded on the first clock edge.
  logic [DW-1:0] ram [512];
  logic [DW-1:0] ram_dout_q;
  bit            loaded;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) ram[i] <= pre(i);
      loaded <= 1'b1;
    end else begin
      if (ram_write_en) ram[ram_addr] <= ram_data_in;
      if (ram_read_en) ram_dout_q <= ram[ram_addr];
    end
  end
  assign ram_data_out = ram_dout_q;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] ref_mem [512];
  int            ptr_m;
  logic [DW-1:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N; k++) if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
`endif
    return -1;
  endfunction

  task automatic post(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c] = 1'b1;
    we[c]  = w;
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    ptr_m   = 0;
    last_rd = '0;
  endtask

  // Entered at IDLE+1ns; runs one arbitration and leaves at the next IDLE+1ns.
  task automatic serve(input bit drop, output int g, output logic [N-1:0] ack_seen,
                       output logic [DW-1:0] rd_seen);
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_rd;
    g = pick(req);
    if (g < 0) begin
      @(posedge clk); #1;
      check("idle_ack", 32'(ack), 0);
      check("idle_strobe", {30'd0, ram_write_en, ram_read_en}, 0);
      ack_seen = ack;
      rd_seen  = rdata;
      return;
    end
    w = we[g];
    a = addr[g*AW +: AW];
    d = wdata[g*DW +: DW];
    @(posedge clk); #1;
    check("issue_write_en", 32'(ram_write_en), 32'(w));
    check("issue_read_en", 32'(ram_read_en), 32'(!w));
    check("issue_addr", 32'(ram_addr), 32'(a));
    if (w) check("issue_data_in", 32'(ram_data_in), 32'(d));
    check("issue_ack", 32'(ack), 0);
    @(posedge clk); #1;
    exp_rd = w ? last_rd : ref_mem[a];
    check("done_ack", 32'(ack), 32'(1) << g);
    check("done_rdata", 32'(rdata), 32'(exp_rd));
    check("done_strobe", {30'd0, ram_write_en, ram_read_en}, 0);
    ack_seen = ack;
    rd_seen  = rdata;
    if (w) ref_mem[a] = d;
    else   last_rd = ref_mem[a];
    ptr_m = (g + 1) % N;
    if (drop) req[g] = 1'b0;
    @(posedge clk); #1;
    check("post_ack_idle", 32'(ack), 0);
  endtask

  typedef struct {
    int            core;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [N-1:0]  exp_ack;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int            g;
    logic [N-1:0]  acks;
    logic [DW-1:0] rds;
    int            exp4 [4];
    int            exp6 [4];

    vecs[0] = '{2, 1'b1, 9'h1A5, 16'hBEEF, 8'h04, 16'h0000};
    vecs[1] = '{2, 1'b0, 9'h1A5, 16'h0000, 8'h04, 16'hBEEF};
    vecs[2] = '{5, 1'b1, 9'h003, 16'h1234, 8'h20, 16'hBEEF};
    vecs[3] = '{0, 1'b0, 9'h003, 16'h0000, 8'h01, 16'h1234};
    vecs[4] = '{7, 1'b1, 9'h1FF, 16'hFFFF, 8'h80, 16'h1234};
    vecs[5] = '{1, 1'b0, 9'h000, 16'h0000, 8'h02, 16'hA500};
    vecs[6] = '{4, 1'b0, 9'h1FF, 16'h0000, 8'h10, 16'hFFFF};
    vecs[7] = '{3, 1'b0, 9'h010, 16'h0000, 8'h08, 16'hA570};
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp4 = '{3, 3, 3, 3};
    exp6 = '{1, 1, 1, 1};
`else
    exp4 = '{3, 5, 3, 5};
    exp6 = '{1, 4, 1, 4};
`endif
    for (int i = 0; i < 512; i++) ref_mem[i] = pre(i);
    we = '0; addr = '0; wdata = '0; req = '0;

    do_reset();
    check("rst_ack", 32'(ack), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_strobes", {30'd0, ram_write_en, ram_read_en}, 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_data_in", 32'(ram_data_in), 0);

    for (int i = 0; i < 8; i++) begin
      post(vecs[i].core, vecs[i].w, vecs[i].a, vecs[i].d);
      serve(1'b1, g, acks, rds);
      check("vec_ack", 32'(acks), 32'(vecs[i].exp_ack));
      check("vec_rdata", 32'(rds), 32'(vecs[i].exp_rd));
    end

    do_reset();
    for (int i = 0; i < N; i++) post(i, 1'b0, 9'(9'h040 + i), 16'h0);
    for (int i = 0; i < N; i++) begin
      serve(1'b1, g, acks, rds);
      check("all8_order", 32'(g), 32'(i));
      check("all8_rdata", 32'(rds), 32'(pre(64 + i)));
    end

    post(7, 1'b0, 9'h050, 16'h0);
    serve(1'b1, g, acks, rds);
    post(0, 1'b0, 9'h051, 16'h0);
    post(6, 1'b0, 9'h052, 16'h0);
    serve(1'b1, g, acks, rds);
    check("wrap_first", 32'(g), 0);
    serve(1'b1, g, acks, rds);
    check("wrap_second", 32'(g), 6);

    post(3, 1'b0, 9'h060, 16'h0);
    post(5, 1'b1, 9'h061, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, g, acks, rds);
      check("hold_alt", 32'(g), 32'(exp4[i]));
    end
    req = '0;

    post(1, 1'b0, 9'h070, 16'h0);
    post(4, 1'b0, 9'h071, 16'h0);
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, g, acks, rds);
      check("prio_hold", 32'(g), 32'(exp6[i]));
    end
    req = '0;

    // Reset arriving in ISSUE must squash the write and the ack.
    do_reset();
    post(6, 1'b1, 9'h020, 16'hDEAD);
    @(posedge clk); #1;
    rst = 1'b1;
    req = '0;
    #1;
    check("rstmid_strobe", {30'd0, ram_write_en, ram_read_en}, 0);
    check("rstmid_ack", 32'(ack), 0);
    @(posedge clk); #1;
    check("rstmid_out", {ack, rdata, 7'd0, ram_addr}, 0);
    check("rstmid_data_in", 32'(ram_data_in), 0);
    rst = 1'b0; ptr_m = 0; last_rd = '0;
    @(posedge clk); #1;
    check("rstmid_no_ack", 32'(ack), 0);
    post(1, 1'b0, 9'h020, 16'h0);
    serve(1'b1, g, acks, rds);
    check("rstmid_ram_untouched", 32'(rds), 32'(pre(32)));

    for (int it = 0; it < 80; it++) begin
      for (int c = 0; c < N; c++)
        if (!req[c] && $urandom_range(0, 2) == 0)
          post(c, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 16'($urandom));
      serve($urandom_range(0, 3) != 0, g, acks, rds);
    end
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
